// File: rtl/vga_pkg.sv
// vga_pkg: shared types and constants for the framebuffer pixel pipeline.
//   FB_W x FB_H    : framebuffer geometry (160x120 at 4x replication of 640x480)
//   FB_DEPTH       : number of framebuffer words
//   RGB_W          : pixel width (4:4:4)
//   fb_state_t     : frame-phase FSM states
//   scan_t         : one pipeline slot of timing-generator data
package vga_pkg;
  localparam int FB_W     = 160;
  localparam int FB_H     = 120;
  localparam int FB_DEPTH = FB_W * FB_H;
  localparam int RGB_W    = 12;
  localparam int ADDR_W   = 15;
  localparam int POS_W    = 10;

  typedef enum logic {
    SCAN   = 1'b0,
    VBLANK = 1'b1
  } fb_state_t;

  typedef struct packed {
    logic [POS_W-1:0] x;
    logic [POS_W-1:0] y;
    logic             von;
    logic             hs;
    logic             vs;
  } scan_t;

  // Idle slot: blanked, syncs at their inactive (high) level.
  localparam scan_t SCAN_IDLE = '{x: '0, y: '0, von: 1'b0, hs: 1'b1, vs: 1'b1};
endpackage

// File: rtl/fb_ram.sv
// fb_ram: simple dual-port synchronous RAM, one write port, one read port.
//   clk          : clock
//   we/waddr/wdata : write port (address must be < DEPTH when we=1)
//   raddr/rdata  : read port, 1-cycle latency, read-first on collision
// Contents are not reset so the array maps onto block RAM.
module fb_ram
  import vga_pkg::*;
#(
  parameter int DEPTH = FB_DEPTH,
  parameter int AW    = ADDR_W,
  parameter int DW    = RGB_W
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Both accesses in one process: the read samples the pre-write word.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/fb_pixel_pipeline.sv
// fb_pixel_pipeline: scales a 160x120 framebuffer up to the VGA scan and
// aligns hsync/vsync with the pixel data (3 cycles in to out).
//   clk, reset          : pixel clock, async active-low reset
//   curr_x/curr_y, video_on, hsync_in, vsync_in : timing generator inputs
//   sw                  : colour invert request, sampled at frame start
//   wr_valid/wr_ready/wr_addr/wr_data : host write port, open only in VBLANK
//   pixel_rgb, hsync, vsync : aligned VGA outputs
//   frame_start, frame_count : frame pulse and 8-bit wrapping counter
//   wr_err              : sticky, set by a write to an out-of-range address
// Stages: S0 input register, S1 address compute + RAM read issue,
// S2 RAM data return (registered inside fb_ram), S3 output register.
module fb_pixel_pipeline
  import vga_pkg::*;
#(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int SCALE_SHIFT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [POS_W-1:0]  curr_x,
  input  logic [POS_W-1:0]  curr_y,
  input  logic              video_on,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              sw,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [RGB_W-1:0]  wr_data,
  output logic [RGB_W-1:0]  pixel_rgb,
  output logic              hsync,
  output logic              vsync,
  output logic              frame_start,
  output logic [7:0]        frame_count,
  output logic              wr_err
);

  localparam int SCL_W  = H_ACTIVE >> SCALE_SHIFT;
  localparam int SCL_H  = V_ACTIVE >> SCALE_SHIFT;
  localparam int DEPTH  = SCL_W * SCL_H;
  localparam int STAGES = 1;
  localparam logic [POS_W-1:0] H_LIM = POS_W'(H_ACTIVE);
  localparam logic [POS_W-1:0] V_LIM = POS_W'(V_ACTIVE);

  scan_t             s0, s2;
  logic [STAGES:0]   vld_pipe;   // [0]: S0 holds real input, [1]: S2 does
  fb_state_t         state, state_nxt;
  logic              frame_go;
  logic              invert;
  logic [31:0]       addr_full;
  logic [ADDR_W-1:0] rd_addr;
  logic [RGB_W-1:0]  rd_data;
  logic              wr_fire, wr_in_range, blank;

  // ---------------- S0 / S2 timing pipeline ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_pipe <= '0;
      s0       <= SCAN_IDLE;
      s2       <= SCAN_IDLE;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], 1'b1};
      s0       <= '{x: curr_x, y: curr_y, von: video_on, hs: hsync_in, vs: vsync_in};
      s2       <= s0;
    end
  end

  // ---------------- S1 address compute ----------------
  // Off-screen positions can overflow the buffer; they are blanked at S3,
  // so the read is just parked on word 0.
  always_comb begin
    addr_full = (32'(s0.y) >> SCALE_SHIFT) * 32'(SCL_W) + (32'(s0.x) >> SCALE_SHIFT);
    rd_addr   = (addr_full < 32'(DEPTH)) ? addr_full[ADDR_W-1:0] : '0;
  end

  // ---------------- host write port ----------------
  assign wr_ready    = (state == VBLANK);
  assign wr_fire     = wr_valid & wr_ready;
  assign wr_in_range = (wr_addr < ADDR_W'(DEPTH));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                       wr_err <= 1'b0;
    else if (wr_fire && !wr_in_range) wr_err <= 1'b1;
  end

  fb_ram #(.DEPTH(DEPTH), .AW(ADDR_W), .DW(RGB_W)) u_ram (
    .clk   (clk),
    .we    (wr_fire & wr_in_range),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // ---------------- frame-phase FSM (on S0 values) ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= VBLANK;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    frame_go  = 1'b0;
    case (state)
      SCAN:   if (vld_pipe[0] && s0.y == V_LIM) state_nxt = VBLANK;
      VBLANK: if (vld_pipe[0] && s0.y == '0) begin
        state_nxt = SCAN;
        frame_go  = 1'b1;
      end
      default: state_nxt = VBLANK;
    endcase
  end

  // The invert flag only moves at frame start, so a frame is uniformly
  // inverted or not regardless of when sw toggles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_start <= 1'b0;
      frame_count <= '0;
      invert      <= 1'b0;
    end else begin
      frame_start <= frame_go;
      if (frame_go) begin
        frame_count <= frame_count + 8'd1;
        invert      <= sw;
      end
    end
  end

  // ---------------- S3 output register ----------------
  assign blank = !vld_pipe[1] || !s2.von || (s2.x >= H_LIM) || (s2.y >= V_LIM);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pixel_rgb <= '0;
      hsync     <= 1'b1;
      vsync     <= 1'b1;
    end else begin
      pixel_rgb <= blank ? '0 : (invert ? ~rd_data : rd_data);
      hsync     <= s2.hs;
      vsync     <= s2.vs;
    end
  end

endmodule

// File: doc/fb_pixel_pipeline.md
FB_PIXEL_PIPELINE -- requirements
Module: fb_pixel_pipeline

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-003 SHALL have parameter SCALE_SHIFT, default 2, log2 of the pixel replication factor, giving a 160x120 framebuffer.
REQ-004 SHALL have port clk, input, 1 bit: 25 MHz pixel clock, the block's only clock.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have ports curr_x and curr_y, inputs, 10 bits each: scan position from the timing generator.
REQ-007 SHALL have ports video_on, hsync_in and vsync_in, inputs, 1 bit each: timing-generator outputs.
REQ-008 SHALL have port sw, input, 1 bit: colour-invert request.
REQ-009 SHALL have ports wr_valid (input, 1 bit), wr_ready (output, 1 bit), wr_addr (input, 15 bits) and wr_data (input, 12 bits): host framebuffer write port.
REQ-010 SHALL have ports pixel_rgb (output, 12 bits), hsync and vsync (outputs, 1 bit each): aligned VGA outputs.
REQ-011 SHALL have ports frame_start (output, 1-cycle pulse), frame_count (output, 8 bits) and wr_err (output, sticky, 1 bit).

Function
REQ-012 SHALL implement a 4-stage pipeline: S0 input register, S1 address compute and RAM read issue, S2 RAM data return, S3 output register.
REQ-013 SHALL give exactly 3 cycles of latency from curr_x/curr_y/video_on/hsync_in/vsync_in to pixel_rgb/hsync/vsync; hsync and vsync SHALL be delayed identically to the pixel data.
REQ-014 SHALL compute the read address as (y>>SCALE_SHIFT)*(H_ACTIVE>>SCALE_SHIFT) + (x>>SCALE_SHIFT), 15 bits unsigned, maximum 19199.
REQ-015 SHALL drive pixel_rgb = 12'h000 when the delayed video_on is 0, or when the delayed x >= H_ACTIVE or y >= V_ACTIVE, whatever the RAM returns.
REQ-016 SHALL output the bitwise inverse (~data) of the RAM data when the latched invert flag is 1, and the data unchanged otherwise.
REQ-017 SHALL run an FSM on the S0 values with two states, SCAN and VBLANK.
REQ-018 SHALL move SCAN->VBLANK when the S0 y equals V_ACTIVE.
REQ-019 SHALL move VBLANK->SCAN when the S0 y equals 0.
REQ-020 On the VBLANK->SCAN transition, SHALL pulse frame_start for 1 cycle, increment frame_count (wrapping 255->0) and latch sw into the invert flag.
REQ-021 SHALL hold the invert flag constant within a frame, so sw changes mid-frame have no visible effect until the next frame.
REQ-022 SHALL drive wr_ready = 1 only in VBLANK; a write completes on a cycle where wr_valid and wr_ready are both 1.
REQ-023 SHALL write wr_data to RAM for a completing write with wr_addr < 19200.
REQ-024 SHALL consume but discard a completing write with wr_addr >= 19200, and set wr_err to 1 until reset.
REQ-025 SHALL not accept any write in SCAN; a host holding wr_valid stalls until VBLANK.
REQ-026 SHALL return the old RAM data when a read and a write hit the same address in the same cycle (read-first).

Reset
REQ-027 While reset is low, SHALL force pixel_rgb=0, hsync=1, vsync=1, frame_start=0, frame_count=0, wr_err=0, invert flag=0, all pipeline valid/sync stages to the inactive level, and the FSM to VBLANK (so wr_ready=1).
REQ-028 SHALL not reset the RAM contents.
REQ-029 SHALL discard pipeline contents on reset mid-frame, with the first frame_start occurring at the first S0 y==0 after release.

Structure
REQ-030 SHALL place the FSM state typedef, FB_W=160, FB_H=120, FB_DEPTH=19200 and RGB_W=12 in shared package vga_pkg.
REQ-031 SHALL contain one sub-module, fb_ram: a simple dual-port (1 write, 1 read) 12x19200 synchronous RAM, 1-cycle read latency, read-first, inferable as BRAM.

Verification
REQ-032 After reset, write 12'hABC to addr 0 in VBLANK, then scan x=0..3,y=0 -> pixel_rgb=12'hABC on 4 consecutive cycles, starting 3 cycles after x=0.
REQ-033 With sw=1 at the y=0 transition and RAM addr 161 = 12'h0F0 -> pixel at (4,4) = 12'hF0F; toggling sw mid-frame leaves the output unchanged.
REQ-034 Hold wr_valid=1 during SCAN -> wr_ready=0 and no RAM change; at y=480 wr_ready rises and the write completes in that cycle.
REQ-035 Write to addr 19200 -> handshake completes, wr_err=1 and stays 1; RAM addr 0..19199 unchanged.
REQ-036 Run 256 frames -> 256 frame_start pulses and frame_count wraps to 0; hsync/vsync match the inputs delayed by exactly 3 cycles.
REQ-037 Assert reset mid-line at (300,200) -> next cycle outputs are 0/1/1 and wr_ready=1; after release the first frame_start comes at y=0.
